aes_iter_core: RTL and testbench
================================

AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words; legal values are 4, 6 and 8 (AES-128/192/256).
REQ-002 SHALL derive localparam NR = NK + 6 (round count); any other NK value SHALL be an elaboration-time error.
REQ-003 SHALL have clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have in_valid  input  1  plaintext/key pair offered.
REQ-006 SHALL have in_ready  output  1  core can accept a block this cycle.
REQ-007 SHALL have in_data  input  128  plaintext, byte 0 at MSB, column-major per FIPS-197.
REQ-008 SHALL have in_key  input  NK*32  cipher key, byte 0 at MSB.
REQ-009 SHALL have out_valid  output  1  ciphertext available.
REQ-010 SHALL have out_ready  input  1  consumer accepts ciphertext.
REQ-011 SHALL have out_data  output  128  ciphertext, same byte order as in_data.
REQ-012 SHALL have busy  output  1  high while rounds are in progress.

Function
REQ-013 SHALL implement FIPS-197 encryption only; the data block SHALL be 128 bits for every NK.
REQ-014 SHALL be iterative, with one shared round datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey.
REQ-015 SHALL use a three-state FSM: IDLE, ROUND, DONE.
REQ-016 in_ready SHALL equal (state==IDLE) OR (state==DONE AND out_ready).
REQ-017 An input handshake SHALL occur when in_valid AND in_ready at a rising edge.
REQ-018 On an input handshake, the core SHALL register in_key, load state_reg with in_data XOR roundkey[0], set round counter rnd=1 and enter ROUND.
REQ-019 Round keys SHALL come from a full key schedule of 4*(NR+1) words computed from the registered key.
REQ-020 roundkey[r] SHALL be schedule words 4r..4r+3.
REQ-021 In ROUND with rnd<NR, each edge SHALL apply a full round with roundkey[rnd] and increment rnd.
REQ-022 In ROUND with rnd==NR, the edge SHALL apply the final round (no MixColumns) with roundkey[NR], write the result to out_data and enter DONE.
REQ-023 out_valid SHALL be high exactly while in DONE.
REQ-024 Latency SHALL be NR cycles: out_valid rises NR edges after the input handshake edge (10/12/14 for NK 4/6/8).
REQ-025 busy SHALL be high exactly while in ROUND; in_valid SHALL be ignored in ROUND.
REQ-026 In DONE with out_ready=0, out_data and out_valid SHALL hold stable indefinitely.
REQ-027 In DONE with out_ready=1 and in_valid=0, the core SHALL go to IDLE; out_data SHALL keep its last value.
REQ-028 In DONE with out_ready=1 and in_valid=1, the output handshake and a new input handshake SHALL both complete on the same edge (REQ-018 applies), giving back-to-back throughput of one block per NR+1 cycles.
REQ-029 in_data and in_key SHALL be sampled only at the handshake edge; later changes SHALL NOT affect the block in flight.
REQ-030 rnd SHALL be ceil(log2(NR+1)) bits wide and SHALL never exceed NR.

Reset
REQ-031 Asserting rst_n low SHALL immediately, without a clock, force state=IDLE, rnd=0, state_reg=0, key register=0, out_data=0, out_valid=0 and busy=0.
REQ-032 in_ready SHALL read 1 during reset and after reset is released.
REQ-033 Reset asserted mid-ROUND or in DONE SHALL discard the block with no output handshake.
REQ-034 The first rising edge after rst_n deasserts SHALL be able to accept a block.

Verification
REQ-035 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 edges after accept.
REQ-036 NK=4/6/8, key 000102..(16/24/32 bytes), pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 respectively.
REQ-037 Hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, busy=0; then pulse out_ready -> IDLE next edge.
REQ-038 out_ready=1 and in_valid=1 held constantly with a stream of 4 FIPS vectors -> accepts every 11 cycles (NK=4) and all outputs correct in order.
REQ-039 Toggle in_data/in_key every cycle during ROUND -> result matches the value sampled at the handshake.
REQ-040 Drop rst_n between clock edges at rnd=5 -> all outputs zero immediately, no out_valid; a new vector after release gives the correct result.

Source files
------------

// File: rtl/aes_iter_core.sv
// AES encryption core (FIPS-197), iterative: one shared round datapath, one round per clock.
// NK selects the key length in 32-bit words (4/6/8); the data block is always 128 bits.
module aes_iter_core #(
   parameter int NK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic [NK*32-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             busy
);
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam int RW = $clog2(NR + 1);

   if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_iter_core: NK must be 4, 6 or 8");
   end

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse computed as a^254 (so 0 maps to 0), then the FIPS affine map.
   function automatic logic [7:0] sub_byte(input logic [7:0] a);
      logic [7:0]  inv;
      logic [7:0]  sq;
      logic [15:0] d;
      inv = 8'h01;
      sq  = a;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      d = {inv, inv};
      return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
   endfunction

   // Full schedule, word 0 at the MSB end; round key r occupies words 4r..4r+3.
   function automatic logic [32*NW-1:0] expand_key(input logic [NK*32-1:0] key);
      logic [31:0]      w [NW];
      logic [31:0]      t;
      logic [7:0]       rc;
      logic [32*NW-1:0] flat;
      rc   = 8'h01;
      flat = '0;
      for (int i = 0; i < NW; i++) begin
         if (i < NK) begin
            w[i] = key[NK*32-1-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % NK == 0) begin
               t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
               rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-NK] ^ t;
         end
         flat[32*NW-1-32*i -: 32] = w[i];
      end
      return flat;
   endfunction

   // Byte k of the block is row k%4, column k/4; byte 0 sits at the MSB.
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   m [16];
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            b[4*c+r] = sub_byte(s[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            m[4*c+r] = xtime(b[4*c+r]) ^ xtime(b[4*c+(r+1)%4]) ^ b[4*c+(r+1)%4]
                     ^ b[4*c+(r+2)%4] ^ b[4*c+(r+3)%4];
         end
      end
      for (int k = 0; k < 16; k++) begin
         o[127-8*k -: 8] = (last ? b[k] : m[k]) ^ rk[127-8*k -: 8];
      end
      return o;
   endfunction

   state_t           r_fsm;
   state_t           w_fsm_nxt;
   logic [RW-1:0]    r_rnd;
   logic [127:0]     r_state;
   logic [127:0]     r_out;
   logic [NK*32-1:0] r_key;
   logic [32*NW-1:0] w_sched;
   logic [127:0]     w_rk;
   logic [127:0]     w_round;
   logic             w_accept;
   logic             w_last;

   assign w_sched   = expand_key(r_key);
   assign w_rk      = w_sched[32*NW-1-128*int'(r_rnd) -: 128];
   assign w_last    = (r_rnd == RW'(NR));
   assign w_round   = aes_round(r_state, w_rk, w_last);
   assign in_ready  = (r_fsm == S_IDLE) || (r_fsm == S_DONE && out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_fsm == S_DONE);
   assign busy      = (r_fsm == S_ROUND);
   assign out_data  = r_out;

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         S_IDLE:  if (w_accept) w_fsm_nxt = S_ROUND;
         S_ROUND: if (w_last) w_fsm_nxt = S_DONE;
         S_DONE: begin
            if (w_accept) w_fsm_nxt = S_ROUND;
            else if (out_ready) w_fsm_nxt = S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // An accept in DONE takes priority over the idle hold, so a new block starts on the drain edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rnd   <= '0;
         r_state <= '0;
         r_key   <= '0;
         r_out   <= '0;
      end else if (w_accept) begin
         r_key   <= in_key;
         r_state <= in_data ^ in_key[NK*32-1 -: 128];
         r_rnd   <= RW'(1);
      end else if (r_fsm == S_ROUND) begin
         r_state <= w_round;
         if (w_last) begin
            r_out <= w_round;
            r_rnd <= '0;
         end else begin
            r_rnd <= r_rnd + RW'(1);
         end
      end
   end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: FIPS known-answer table, random blocks against a byte-array AES model,
// and hand-written sequences for output hold, streaming, input scrambling and asynchronous reset.
module tb_aes_iter_core;
   logic         clk;
   logic         rst_n;
   logic         v4, v6, v8;
   logic         rdy4, rdy6, rdy8;
   logic         ov4, ov6, ov8;
   logic [127:0] od4, od6, od8;
   logic         busy4, busy6, busy8;
   logic [127:0] in_data;
   logic [255:0] key256;
   logic         out_ready;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb [256];
   logic [7:0] rcon [11];

   typedef struct {
      int           nk;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t tbl [4];
   vec_t sv [4];

   aes_iter_core #(.NK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(in_data),
      .in_key(key256[255:128]), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .busy(busy4));
   aes_iter_core #(.NK(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6), .in_data(in_data),
      .in_key(key256[255:64]), .out_valid(ov6), .out_ready(out_ready), .out_data(od6),
      .busy(busy6));
   aes_iter_core #(.NK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(in_data),
      .in_key(key256), .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
      .busy(busy8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // Polynomial multiply then reduce modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic logic [127:0] model_enc(input int nk, input logic [255:0] key,
                                              input logic [127:0] pt);
      logic [31:0]  w [60];
      logic [7:0]   st [4][4];
      logic [7:0]   sh [4][4];
      logic [31:0]  t;
      logic [127:0] res;
      int           nr;
      nr = nk + 6;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = key[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon[i/nk], 24'h000000};
            else if (nk == 8 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               sh[r][c] = sb[st[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rd < nr) begin
               st[0][c] = gf_mul(sh[0][c], 8'h02) ^ gf_mul(sh[1][c], 8'h03) ^ sh[2][c] ^ sh[3][c];
               st[1][c] = sh[0][c] ^ gf_mul(sh[1][c], 8'h02) ^ gf_mul(sh[2][c], 8'h03) ^ sh[3][c];
               st[2][c] = sh[0][c] ^ sh[1][c] ^ gf_mul(sh[2][c], 8'h02) ^ gf_mul(sh[3][c], 8'h03);
               st[3][c] = gf_mul(sh[0][c], 8'h03) ^ sh[1][c] ^ sh[2][c] ^ gf_mul(sh[3][c], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) st[r][c] = sh[r][c];
            end
            for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ w[4*rd+c][31-8*r -: 8];
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = st[r][c];
      return res;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input int nk);
      return (nk == 4) ? rdy4 : (nk == 6) ? rdy6 : rdy8;
   endfunction

   function automatic logic ovf(input int nk);
      return (nk == 4) ? ov4 : (nk == 6) ? ov6 : ov8;
   endfunction

   function automatic logic [127:0] odf(input int nk);
      return (nk == 4) ? od4 : (nk == 6) ? od6 : od8;
   endfunction

   task automatic set_valid(input int nk, input logic v);
      v4 = (nk == 4) ? v : 1'b0;
      v6 = (nk == 6) ? v : 1'b0;
      v8 = (nk == 8) ? v : 1'b0;
   endtask

   // One block: accept, optionally scramble inputs and in_valid while it runs, check latency/data/drain.
   task automatic run_block(input int nk, input logic [255:0] key, input logic [127:0] pt,
                            input logic [127:0] exp, input bit scramble, input string nm);
      int n;
      key256  = key;
      in_data = pt;
      set_valid(nk, 1'b1);
      n = 0;
      while (!rdy(nk) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      set_valid(nk, 1'b0);
      n = 0;
      while (!ovf(nk) && n < 40) begin
         if (scramble) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            key256  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            set_valid(nk, 1'($urandom_range(0, 1)));
         end
         @(posedge clk); #1; n++;
      end
      set_valid(nk, 1'b0);
      chk({nm, " latency"}, 128'(n), 128'(nk + 6));
      chk({nm, " data"}, odf(nk), exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " drained"}, {126'd0, ovf(nk), rdy(nk)}, 128'd1);
   endtask

   initial begin
      logic [7:0]   inv;
      logic [7:0]   aff;
      logic [7:0]   cst;
      logic [127:0] hold_ct;
      int           n;
      int           idx;
      int           nout;
      int           cyc;
      int           last_acc;
      logic         acc;
      logic         oh;
      logic [127:0] odv;

      cst = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            aff[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
         sb[x] = aff;
      end
      rcon = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

      tbl[0] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
      tbl[1] = '{4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      tbl[2] = '{6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                 128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
      tbl[3] = '{8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                 128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

      v4 = 1'b0; v6 = 1'b0; v8 = 1'b0;
      out_ready = 1'b0;
      in_data = '0;
      key256 = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset outputs", {123'd0, rdy4, ov4, busy4, ov8, busy8}, 128'b10000);
      chk("reset out_data", od4, 128'd0);
      #20 rst_n = 1'b1;

      // Known answers; the first one is offered on the first edge after reset release.
      for (int i = 0; i < 4; i++)
         run_block(tbl[i].nk, tbl[i].key, tbl[i].pt, tbl[i].ct, 1'b0, $sformatf("kat%0d", i));

      for (int it = 0; it < 24; it++) begin
         int           nk;
         logic [255:0] k;
         logic [127:0] p;
         nk = 4 + 2 * int'($urandom_range(0, 2));
         for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
         for (int j = 0; j < 4; j++) p[32*j +: 32] = $urandom;
         run_block(nk, k, p, model_enc(nk, k, p), it[0], $sformatf("rand%0d_nk%0d", it, nk));
      end

      // Output held in DONE while the consumer stalls.
      key256 = tbl[0].key; in_data = tbl[0].pt; hold_ct = tbl[0].ct;
      v4 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0;
      n = 0;
      while (!ov4 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk("hold latency", 128'(n), 128'd10);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold cyc%0d", i), {ov4, rdy4, busy4, od4[124:0]}, {3'b100, hold_ct[124:0]});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hold release idle", {126'd0, ov4, rdy4}, 128'd1);
      chk("hold release data kept", od4, hold_ct);

      // Back-to-back stream with out_ready and in_valid held high.
      sv[0] = tbl[0]; sv[1] = tbl[1]; sv[2] = tbl[0]; sv[3] = tbl[1];
      sv[2].pt = 128'h00112233445566778899aabbccddeeff;
      sv[2].ct = model_enc(4, sv[2].key, sv[2].pt);
      out_ready = 1'b1;
      idx = 0; nout = 0; cyc = 0; last_acc = -1;
      key256 = sv[0].key; in_data = sv[0].pt; v4 = 1'b1;
      while (nout < 4 && cyc < 200) begin
         acc = v4 && rdy4;
         oh  = ov4 && out_ready;
         odv = od4;
         @(posedge clk); #1; cyc++;
         if (oh) begin
            chk($sformatf("stream out%0d", nout), odv, sv[nout].ct);
            nout++;
         end
         if (acc) begin
            if (last_acc >= 0) chk($sformatf("stream gap%0d", idx), 128'(cyc - last_acc), 128'd11);
            last_acc = cyc;
            idx++;
            if (idx < 4) begin
               key256 = sv[idx].key; in_data = sv[idx].pt;
            end else begin
               v4 = 1'b0;
            end
         end
      end
      chk("stream outputs seen", 128'(nout), 128'd4);
      v4 = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset between edges at rnd=5 discards the block.
      key256 = tbl[1].key; in_data = tbl[1].pt;
      v4 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      chk("pre-reset busy", {127'd0, busy4}, 128'd1);
      rst_n = 1'b0;
      #1;
      chk("midround reset flags", {125'd0, ov4, busy4, rdy4}, 128'd1);
      chk("midround reset data", od4, 128'd0);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk($sformatf("reset hold%0d", i), {126'd0, ov4, busy4}, 128'd0);
      end
      #3 rst_n = 1'b1;
      run_block(4, tbl[0].key, tbl[0].pt, tbl[0].ct, 1'b0, "after reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
